// File: rtl/price_bin2bcd_seq_if.sv
// Start/done handshake and result bus between a price source and the BCD converter.
interface price_bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_price_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_price_bcd;
  logic [DIGITS-1:0]     o_lz_mask;

  modport master (
    output i_start, i_price_bin,
    input  o_busy, o_done, o_price_bcd, o_lz_mask
  );

  modport slave (
    input  i_start, i_price_bin,
    output o_busy, o_done, o_price_bcd, o_lz_mask
  );
endinterface

// File: rtl/price_bin2bcd_seq.sv
// Iterative double-dabble price converter with leading-zero mask; result BIN_W+1 edges after start.
// No queueing: start is only taken while idle, requests during a conversion are dropped.
module price_bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  price_bin2bcd_seq_if.slave   bcd_if
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_IN    = (64'd1 << BIN_W) - 64'd1;
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;

  if (BIN_W < 2) begin : g_bin_w_err
    $error("price_bin2bcd_seq: BIN_W must be at least 2");
  end
  if (DEC_RANGE <= MAX_IN) begin : g_digits_err
    $error("price_bin2bcd_seq: DIGITS too small to hold 2**BIN_W-1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIN_W-1:0]     r_sh;
  logic [4*DIGITS-1:0]  r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic [4*DIGITS-1:0]  r_price_bcd;
  logic [DIGITS-1:0]    r_lz_mask;
  logic [4*DIGITS-1:0]  w_acc_adj;
  logic [DIGITS-1:0]    w_lz;
  logic                 w_hi_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bcd_if.i_start) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Digits >= 5 get +3 before the shift so they carry correctly into the next BCD digit.
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Digit 0 is never blanked so a zero price still shows a single '0'.
  always_comb begin
    w_lz      = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero = w_hi_zero & (r_acc[4*i +: 4] == 4'd0);
      w_lz[i]   = w_hi_zero;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_price_bcd <= '0;
      r_lz_mask   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bcd_if.i_start) begin
            r_sh  <= bcd_if.i_price_bin;
            r_acc <= '0;
            r_cnt <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          r_acc <= {w_acc_adj[4*DIGITS-2:0], r_sh[BIN_W-1]};
          r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FINISH: begin
          r_price_bcd <= r_acc;
          r_lz_mask   <= w_lz;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd_if.o_busy      = (r_state != IDLE);
  assign bcd_if.o_done      = r_done;
  assign bcd_if.o_price_bcd = r_price_bcd;
  assign bcd_if.o_lz_mask   = r_lz_mask;

endmodule

// File: tb/tb_price_bin2bcd_seq.sv
// Directed checks of the BCD price converter: default 8-bit/3-digit instance and a 4-bit/2-digit one.
module tb_price_bin2bcd_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  price_bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus8 ();
  price_bin2bcd_seq_if #(.BIN_W(4), .DIGITS(2)) bus4 ();

  price_bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .i_clk  (clk),
    .i_rst  (rst),
    .bcd_if (bus8)
  );

  price_bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .i_clk  (clk),
    .i_rst  (rst),
    .bcd_if (bus4)
  );

  localparam logic [7:0]  SW_IN  [8] = '{8'd0, 8'd1, 8'd7, 8'd10, 8'd15, 8'd99, 8'd100, 8'd255};
  localparam logic [11:0] SW_BCD [8] = '{12'h000, 12'h001, 12'h007, 12'h010,
                                         12'h015, 12'h099, 12'h100, 12'h255};
  localparam logic [2:0]  SW_LZ  [8] = '{3'b110, 3'b110, 3'b110, 3'b100,
                                         3'b100, 3'b100, 3'b000, 3'b000};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns edges from the accepting edge to the first done, and busy samples seen meanwhile.
  task automatic run8(input logic [7:0] p, output int lat, output int nbusy);
    bus8.i_start     = 1'b1;
    bus8.i_price_bin = p;
    tick();
    bus8.i_start     = 1'b0;
    bus8.i_price_bin = 8'($urandom);
    lat   = -1;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus8.o_busy) nbusy++;
      tick();
      if (bus8.o_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run4(input logic [3:0] p, output int lat);
    bus4.i_start     = 1'b1;
    bus4.i_price_bin = p;
    tick();
    bus4.i_start     = 1'b0;
    bus4.i_price_bin = 4'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus4.o_done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus8.i_start     = 1'b0;
    bus8.i_price_bin = '0;
    bus4.i_start     = 1'b0;
    bus4.i_price_bin = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus8.o_busy), 32'd0);
    check("rst_done", 32'(bus8.o_done), 32'd0);
    check("rst_bcd",  32'(bus8.o_price_bcd), 32'h000);
    check("rst_lz",   32'(bus8.o_lz_mask), 32'd0);
    check("rst4_bcd", 32'(bus4.o_price_bcd), 32'h00);
    rst = 1'b0;
    tick();

    // Basic conversion: 9 busy cycles, single-cycle done.
    run8(8'd5, lat, nbusy);
    check("t1_lat",   32'(lat), 32'd9);
    check("t1_busy",  32'(nbusy), 32'd9);
    check("t1_bcd",   32'(bus8.o_price_bcd), 32'h005);
    check("t1_lz",    32'(bus8.o_lz_mask), 32'b110);
    check("t1_dbusy", 32'(bus8.o_busy), 32'd0);
    tick();
    check("t1_done_low", 32'(bus8.o_done), 32'd0);
    check("t1_hold",     32'(bus8.o_price_bcd), 32'h005);

    for (int i = 0; i < 8; i++) begin
      run8(SW_IN[i], lat, nbusy);
      check($sformatf("sweep%0d_lat", i), 32'(lat), 32'd9);
      check($sformatf("sweep%0d_bcd", i), 32'(bus8.o_price_bcd), 32'(SW_BCD[i]));
      check($sformatf("sweep%0d_lz", i),  32'(bus8.o_lz_mask), 32'(SW_LZ[i]));
      tick();
    end

    // Start requests while busy must be ignored and not queued.
    bus8.i_start     = 1'b1;
    bus8.i_price_bin = 8'd200;
    tick();
    bus8.i_price_bin = 8'd50;
    repeat (3) tick();
    bus8.i_start = 1'b0;
    lat = -1;
    for (int i = 4; i <= 40; i++) begin
      tick();
      if (bus8.o_done) begin
        lat = i;
        break;
      end
    end
    check("t3_lat", 32'(lat), 32'd9);
    check("t3_bcd", 32'(bus8.o_price_bcd), 32'h200);
    check("t3_lz",  32'(bus8.o_lz_mask), 32'b000);
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus8.o_done) ndone++;
      if (bus8.o_busy) nbusy++;
    end
    check("t3_extra_done", 32'(ndone), 32'd0);
    check("t3_extra_busy", 32'(nbusy), 32'd0);

    // Back-to-back: the second start is raised in the done cycle of the first.
    run8(8'd5, lat, nbusy);
    check("t4_first_lat", 32'(lat), 32'd9);
    check("t4_first_bcd", 32'(bus8.o_price_bcd), 32'h005);
    run8(8'd10, lat, nbusy);
    check("t4_second_lat", 32'(lat), 32'd9);
    check("t4_second_bcd", 32'(bus8.o_price_bcd), 32'h010);
    check("t4_second_lz",  32'(bus8.o_lz_mask), 32'b100);
    tick();

    // Reset mid-conversion clears outputs immediately, without waiting for a clock edge.
    bus8.i_start     = 1'b1;
    bus8.i_price_bin = 8'd123;
    tick();
    bus8.i_start = 1'b0;
    repeat (3) tick();
    check("t5_busy_pre", 32'(bus8.o_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(bus8.o_busy), 32'd0);
    check("t5_done", 32'(bus8.o_done), 32'd0);
    check("t5_bcd",  32'(bus8.o_price_bcd), 32'h000);
    check("t5_lz",   32'(bus8.o_lz_mask), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus8.o_done) ndone++;
    end
    check("t5_no_done", 32'(ndone), 32'd0);
    run8(8'd123, lat, nbusy);
    check("t5_lat", 32'(lat), 32'd9);
    check("t5_bcd_after", 32'(bus8.o_price_bcd), 32'h123);
    check("t5_lz_after",  32'(bus8.o_lz_mask), 32'b000);
    tick();

    // Narrow instance: 4-bit input, 2 digits.
    run4(4'd15, lat);
    check("t6_lat15", 32'(lat), 32'd5);
    check("t6_bcd15", 32'(bus4.o_price_bcd), 32'h15);
    check("t6_lz15",  32'(bus4.o_lz_mask), 32'b00);
    tick();
    run4(4'd0, lat);
    check("t6_lat0", 32'(lat), 32'd5);
    check("t6_bcd0", 32'(bus4.o_price_bcd), 32'h00);
    check("t6_lz0",  32'(bus4.o_lz_mask), 32'b10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
